// File: rtl/mem_ctrl_pkg.sv
// Shared widths and burst FSM encoding for the memory channel controllers.
package mem_ctrl_pkg;
  localparam int MEM_DATA_W      = 256;
  localparam int MEM_ADDR_W      = 28;
  localparam int MEM_LEN_W       = 8;
  localparam int MEM_RFIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } burst_state_e;
endpackage

// File: rtl/mem_rd_fifo.sv
// Read-return buffer: head visible combinationally, push lands next cycle.
// Pushes into a full buffer are dropped; the controller throttles so that never happens.
module mem_rd_fifo #(
  parameter int W     = 257,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst controller: one memory strobe per beat, registered, one cycle after acceptance.
// Writes stall on wd_valid; reads stall when the return buffer could not absorb another beat.
module mem_burst_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int LEN_W       = MEM_LEN_W,
  parameter int RFIFO_DEPTH = MEM_RFIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  input  logic                  wd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_wdin,
  output logic [DATA_W/8-1:0]   mem_wb,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic                  mem_rvld,
  input  logic [DATA_W-1:0]     mem_rdout,
  output logic                  busy,
  output logic                  err_wlast
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(RFIFO_DEPTH) + 1;

  burst_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_waddr_q, mem_waddr_d, mem_raddr_q, mem_raddr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_wdin_q, mem_wdin_d;
  logic [SW-1:0]     mem_wb_q, mem_wb_d;
  logic              mem_wen_q, mem_wen_d, mem_ren_q, mem_ren_d;
  logic              rlast_q, rlast_d, inflight_q, inflight_d, inflast_q, inflast_d;
  logic              err_wlast_q, err_wlast_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_dout;
  logic [CW:0]       outstanding;
  logic              can_issue, last_beat;

  assign last_beat = (cnt_q == len_q);
  // A read strobe on the bus now and the data returning now both still need buffer slots.
  assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, mem_ren_q} + {{CW{1'b0}}, inflight_q};
  assign can_issue   = outstanding < (CW+1)'(RFIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_wen_d   = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdin_d  = mem_wdin_q;
    mem_wb_d    = mem_wb_q;
    mem_ren_d   = 1'b0;
    mem_raddr_d = mem_raddr_q;
    rlast_d     = 1'b0;
    inflight_d  = mem_ren_q;
    inflast_d   = rlast_q;
    err_wlast_d = err_wlast_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        cnt_d   = '0;
        state_d = cmd_write ? ST_WRITE : ST_READ;
      end
      ST_WRITE: if (wd_valid) begin
        mem_wen_d   = 1'b1;
        mem_waddr_d = addr_q;
        mem_wdin_d  = wd_data;
        mem_wb_d    = wd_strb;
        addr_d      = addr_q + ADDR_W'(1);
        cnt_d       = cnt_q + LEN_W'(1);
        if (wd_last != last_beat) err_wlast_d = 1'b1;
        if (last_beat) state_d = ST_IDLE;
      end
      ST_READ: if (can_issue) begin
        mem_ren_d   = 1'b1;
        mem_raddr_d = addr_q;
        rlast_d     = last_beat;
        addr_d      = addr_q + ADDR_W'(1);
        cnt_d       = cnt_q + LEN_W'(1);
        if (last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdin_q  <= '0;
      mem_wb_q    <= '0;
      mem_ren_q   <= 1'b0;
      mem_raddr_q <= '0;
      rlast_q     <= 1'b0;
      inflight_q  <= 1'b0;
      inflast_q   <= 1'b0;
      err_wlast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdin_q  <= mem_wdin_d;
      mem_wb_q    <= mem_wb_d;
      mem_ren_q   <= mem_ren_d;
      mem_raddr_q <= mem_raddr_d;
      rlast_q     <= rlast_d;
      inflight_q  <= inflight_d;
      inflast_q   <= inflast_d;
      err_wlast_q <= err_wlast_d;
    end
  end

  mem_rd_fifo #(.W(DATA_W + 1), .DEPTH(RFIFO_DEPTH)) u_rd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mem_rvld && inflight_q),
    .push_dat ({inflast_q, mem_rdout}),
    .pop      (rd_valid && rd_ready),
    .pop_dat  (fifo_dout),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Buffer storage is not reset, so the head is masked while empty.
  assign rd_valid  = !fifo_empty;
  assign rd_data   = rd_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign rd_last   = rd_valid && fifo_dout[DATA_W];
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign wd_ready  = (state_q == ST_WRITE);
  assign mem_wen   = mem_wen_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdin  = mem_wdin_q;
  assign mem_wb    = mem_wb_q;
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = mem_raddr_q;
  assign err_wlast = err_wlast_q;
  assign busy      = (state_q != ST_IDLE) || mem_ren_q || inflight_q || !fifo_empty;
endmodule
